// File: rtl/nibble_serial_adder_pkg.sv
// Shared slice width and FSM state encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/nibble_serial_adder_add4_slice.sv
// Combinational 4-bit ripple-carry slice; c3 is the carry into bit 3 for signed-overflow detection.
module add4_slice
  import nibble_serial_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a4,
  input  logic [SLICE_W-1:0] b4,
  input  logic               cin,
  output logic [SLICE_W-1:0] s4,
  output logic               cout,
  output logic               c3
);

  logic [SLICE_W:0] w_c;

  always_comb begin
    w_c    = '0;
    s4     = '0;
    w_c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      s4[i]    = a4[i] ^ b4[i] ^ w_c[i];
      w_c[i+1] = (a4[i] & b4[i]) | (w_c[i] & (a4[i] ^ b4[i]));
    end
  end

  assign cout = w_c[SLICE_W];
  assign c3   = w_c[SLICE_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder reusing one 4-bit slice, LSB nibble first; done pulses NIBBLES+1 edges after accept.
// Start is ignored while busy. Define NIBBLE_SERIAL_ADDER_SUB_EN to add the sub port (a-b).
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = SLICE_W * NIBBLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int CW = $clog2(NIBBLES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_ovf;

  logic               w_accept;
  logic               w_run;
  logic               w_last;
  logic [WIDTH-1:0]   w_b_eff;
  logic               w_cin_eff;
  logic [SLICE_W-1:0] w_a4;
  logic [SLICE_W-1:0] w_b4;
  logic [SLICE_W-1:0] w_s4;
  logic               w_cout;
  logic               w_c3;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  // Subtraction as a + ~b + 1; the caller's carry-in is ignored.
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub ? 1'b1 : c_in;
`else
  assign w_b_eff   = b;
  assign w_cin_eff = c_in;
`endif

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_run    = (r_state == ST_RUN);
  assign w_last   = (r_count == CW'(NIBBLES - 1));
  assign w_a4     = r_a[SLICE_W*int'(r_count) +: SLICE_W];
  assign w_b4     = r_b[SLICE_W*int'(r_count) +: SLICE_W];

  add4_slice u_slice (
    .a4   (w_a4),
    .b4   (w_b4),
    .cin  (r_carry),
    .s4   (w_s4),
    .cout (w_cout),
    .c3   (w_c3)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = start ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        busy        = 1'b1;
        w_state_nxt = w_last ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_eff;
      r_carry <= w_cin_eff;
      r_count <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_run) begin
      r_sum[SLICE_W*int'(r_count) +: SLICE_W] <= w_s4;
      r_carry <= w_cout;
      if (w_last) begin
        r_c_out <= w_cout;
        r_ovf   <= w_c3 ^ w_cout;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign sum      = r_sum;
  assign c_out    = r_c_out;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench: random and directed operations against an arithmetic reference model.
`timescale 1ns/1ps
module tb_nibble_serial_adder;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, start, c_in, sub;
  logic [W-1:0] a, b;
  logic         busy, done, c_out, overflow;
  logic [W-1:0] sum;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t mon_e;
  bit   prev_done = 1'b0;
  int   done_seen = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic ms);
    logic [W-1:0] bb;
    logic         ci;
    logic [W:0]   full;
    exp_t         e;
    bb   = ms ? ~mb : mb;
    ci   = ms ? 1'b1 : mc;
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ci};
    e.s  = full[W-1:0];
    e.co = full[W];
    e.ov = (ma[W-1] == bb[W-1]) && (e.s[W-1] != ma[W-1]);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (prev_done) check("done_one_cycle", {31'b0, done}, 32'd0);
    if (done) begin
      done_seen++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pending operation at %0t", $time);
      end else begin
        mon_e = q.pop_front();
        check("sum", {16'b0, sum}, {16'b0, mon_e.s});
        check("c_out", {31'b0, c_out}, {31'b0, mon_e.co});
        check("overflow", {31'b0, overflow}, {31'b0, mon_e.ov});
      end
    end
    prev_done = done;
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                        input logic tc, input logic ts, input int glitch);
    int k;
    int nbusy;
    @(negedge clk);
    a = ta; b = tb2; c_in = tc; sub = ts; start = 1'b1;
    q.push_back(model(ta, tb2, tc, ts));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    k = 2;
    nbusy = 0;
    while (!done && k < 40) begin
      nbusy += int'(busy);
      if (k == glitch) begin
        start = 1'b1;
        a = 16'hAAAA;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles want %0d", k, NIB + 2);
    end else begin
      nbusy += int'(busy);
      check("latency", k, NIB + 2);
      check("busy_cycles", nbusy, NIB + 1);
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen0;
    logic rs;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_sum", {16'b0, sum}, 32'd0);
    check("rst_c_out", {31'b0, c_out}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    reset = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h7FFE, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 3);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, 0);

    // Abort after two RUN edges: nibbles 0 and 1 of 0x1111+0x2222 are already in sum.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("partial_sum", {16'b0, sum}, 32'h0033);
    seen0 = done_seen;
    reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_sum", {16'b0, sum}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (NIB + 3) @(negedge clk);
    check("abort_no_done", done_seen - seen0, 0);
    check("abort_idle_busy", {31'b0, busy}, 32'd0);

    run_op(16'h00FF, 16'h0F01, 1'b1, 1'b0, 0);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
`endif

    for (int i = 0; i < 150; i++) begin
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), rs,
             (i % 5 == 0) ? int'($urandom_range(2, NIB + 1)) : 0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle controller that adds two WIDTH-bit operands by sequencing one 4-bit ripple-carry adder slice, one nibble per cycle, LSB nibble first.
- A carry register links consecutive nibbles.
- Sits beside the lab datapath as the area-minimal wide adder: one slice of hardware, reused NIBBLES times per operation.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; WIDTH = 4*NIBBLES (16 by default); legal range 2..8.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; returns the block to IDLE
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- c_in  input  1  carry-in to nibble 0; captured on accepted start
- busy  output  1  high from the cycle after accept through the DONE cycle
- done  output  1  one-cycle pulse; sum, c_out and overflow are final in this cycle
- sum  output  WIDTH  result, held until the next accepted start
- c_out  output  1  carry out of the MSB nibble, held
- overflow  output  1  signed overflow = carry into bit WIDTH-1 XOR c_out, held

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy, done, sum, c_out, overflow, count, carry and operand registers all 0.
- States: IDLE, RUN, DONE. Encoding is 2 bits: IDLE=0, RUN=1, DONE=2. Any other code returns to IDLE.
- IDLE, start=1:
  - latch a and b into a_reg and b_reg; carry <= c_in; count <= 0; sum <= 0; c_out <= 0; overflow <= 0
  - go to RUN
- IDLE, start=0: stay in IDLE; all held outputs are unchanged.
- RUN, each cycle:
  - the slice adds a_reg[4*count+:4], b_reg[4*count+:4] and carry
  - the slice sum is written to sum[4*count+:4]; carry <= slice cout
  - on count==NIBBLES-1: overflow <= (bit-2 carry XOR bit-3 carry) of the slice, i.e. (carry into the slice MSB) XOR (slice cout); c_out <= slice cout; go to DONE
  - otherwise count <= count+1
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: start accepted at edge T gives done high in the cycle after edge T+NIBBLES. That is NIBBLES+2 cycles from start high to done high inclusive (6 for NIBBLES=4).
- Throughput: next start is accepted in the first IDLE cycle after done, so one operation takes NIBBLES+2 cycles.
- start while busy (RUN or DONE) is ignored, not queued. Operand inputs are don't-care outside the accept cycle.
- Partial sum nibbles are visible in sum during RUN; consumers use sum only when done is high or afterwards.
- Reset asserted mid-RUN aborts immediately: no done pulse, and sum is cleared.
- count is wide enough to hold NIBBLES-1. It never wraps within an operation.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_SUB_EN.
- Defined:
  - adds input port sub (1 bit), captured on accepted start
  - when sub=1, b_reg is stored as ~b and carry starts at 1 (c_in is ignored), so the result is a-b
  - c_out=1 means no borrow; overflow uses the same rule as add
- Undefined: no sub port; the block only adds.

Decomposition:
- Shared package/header holds:
  - state encoding constants (ST_IDLE, ST_RUN, ST_DONE)
  - SLICE_W=4
- One sub-module, add4_slice: a purely combinational 4-bit ripple-carry adder (a4, b4, cin -> s4, cout, c3). c3 is the carry into bit 3, used for overflow.
- The controller instantiates exactly one add4_slice.

Test Plan:
- Basic add: a=0x1234, b=0x4321, c_in=0, start for 1 cycle -> done 6 cycles later (start cycle inclusive); sum=0x5555, c_out=0, overflow=0; busy high for 5 cycles.
- Carry ripples across all nibbles: a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, overflow=0.
- Carry-in and signed overflow: a=0x7FFE, b=0x0000, c_in=1 -> sum=0x7FFF, overflow=0. Then a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, overflow=1.
- Start while busy: accept a=0x0001, b=0x0001; pulse start with a=0xAAAA two cycles later -> exactly one done, sum=0x0002. Back-to-back start in the cycle after done is accepted.
- Reset mid-RUN: assert reset after 2 RUN cycles -> busy=0, sum=0 and state IDLE immediately, no done pulse. A fresh start after reset works normally.
- NIBBLE_SERIAL_ADDER_SUB_EN defined, sub=1:
  - a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0
  - a=0x8000, b=0x0001 -> sum=0x7FFF, overflow=1
